symbol_trade_stats: RTL and testbench

- Consumes parsed market-data messages (symbol, price, quantity, msg_type) from the market data parser.
- Keeps a small per-symbol table holding last trade price and cumulative volume.
- For every trade message, emits one enriched trade event (signed price change, running volume) to the strategy stage over a valid/ready interface.
- Its in_ready output drives the parser's ready_next input.

---
 rtl/symbol_stats_pkg.sv | 30 +++
 rtl/symbol_cam_lookup.sv | 32 +++
 rtl/symbol_trade_stats.sv | 180 ++++++++++++++++++
 tb/tb_symbol_trade_stats.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/symbol_stats_pkg.sv
// rtl/symbol_stats_pkg.sv - shared message/state types for the per-symbol trade statistics block
package symbol_stats_pkg;

  typedef enum logic [1:0] {
    MSG_UNDEF = 2'b00,
    MSG_TRADE = 2'b01,
    MSG_QUOTE = 2'b10,
    MSG_ORDER = 2'b11
  } msg_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_UPDATE,
    ST_EMIT
  } stats_state_t;

  // Default field widths of one table entry (valid, symbol, last_price, volume).
  localparam int ENTRY_SYMBOL_WIDTH = 32;
  localparam int ENTRY_PRICE_WIDTH  = 32;
  localparam int ENTRY_VOLUME_WIDTH = 48;

  typedef struct packed {
    logic                          valid;
    logic [ENTRY_SYMBOL_WIDTH-1:0] symbol;
    logic [ENTRY_PRICE_WIDTH-1:0]  last_price;
    logic [ENTRY_VOLUME_WIDTH-1:0] volume;
  } stats_entry_t;

endpackage

// File: rtl/symbol_cam_lookup.sv
// rtl/symbol_cam_lookup.sv - parallel symbol compare with lowest-index hit and free-slot encoders
module symbol_cam_lookup #(
  parameter int NUM_SYMBOLS  = 8,
  parameter int SYMBOL_WIDTH = 32,
  parameter int IDX_WIDTH    = $clog2(NUM_SYMBOLS)
) (
  input  logic [NUM_SYMBOLS-1:0]  entry_valid,
  input  logic [SYMBOL_WIDTH-1:0] entry_symbol [NUM_SYMBOLS],
  input  logic [SYMBOL_WIDTH-1:0] key,
  output logic                    hit,
  output logic [IDX_WIDTH-1:0]    hit_idx,
  output logic [IDX_WIDTH-1:0]    free_idx,
  output logic                    full
);

  logic [NUM_SYMBOLS-1:0] match;

  // Scan from the top so the lowest matching / free index wins.
  always_comb begin
    match    = '0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NUM_SYMBOLS - 1; i >= 0; i--) begin
      match[i] = entry_valid[i] && (entry_symbol[i] == key);
      if (match[i])       hit_idx  = IDX_WIDTH'(i);
      if (!entry_valid[i]) free_idx = IDX_WIDTH'(i);
    end
    hit  = |match;
    full = &entry_valid;
  end

endmodule

// File: rtl/symbol_trade_stats.sv
// rtl/symbol_trade_stats.sv - per-symbol last price / cumulative volume table emitting enriched trade events
// Optional table clear input enabled by SYMBOL_STATS_CLEAR_EN.
module symbol_trade_stats
  import symbol_stats_pkg::*;
#(
  parameter int NUM_SYMBOLS    = 8,
  parameter int SYMBOL_WIDTH   = 32,
  parameter int PRICE_WIDTH    = 32,
  parameter int QUANTITY_WIDTH = 32,
  parameter int VOLUME_WIDTH   = 48,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
`ifdef SYMBOL_STATS_CLEAR_EN
  input  logic                           clear,
`endif
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SYMBOL_WIDTH-1:0]        in_symbol,
  input  logic [PRICE_WIDTH-1:0]         in_price,
  input  logic [QUANTITY_WIDTH-1:0]      in_quantity,
  input  logic [1:0]                     in_msg_type,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SYMBOL_WIDTH-1:0]        out_symbol,
  output logic [PRICE_WIDTH-1:0]         out_price,
  output logic [PRICE_WIDTH:0]           out_delta,
  output logic [VOLUME_WIDTH-1:0]        out_volume,
  output logic [$clog2(NUM_SYMBOLS)-1:0] out_index,
  output logic                           out_first,
  output logic [CNT_WIDTH-1:0]           drop_count,
  output logic [CNT_WIDTH-1:0]           ignore_count
);

  localparam int IDX_WIDTH = $clog2(NUM_SYMBOLS);
  localparam int SUM_WIDTH = VOLUME_WIDTH + 1;

  // Same layout as stats_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic                    valid;
    logic [SYMBOL_WIDTH-1:0] symbol;
    logic [PRICE_WIDTH-1:0]  last_price;
    logic [VOLUME_WIDTH-1:0] volume;
  } entry_t;

  stats_state_t                state_q, state_d;
  entry_t                      table_q [NUM_SYMBOLS];
  logic [NUM_SYMBOLS-1:0]      entry_valid;
  logic [SYMBOL_WIDTH-1:0]     entry_symbol [NUM_SYMBOLS];
  logic [SYMBOL_WIDTH-1:0]     sym_q;
  logic [PRICE_WIDTH-1:0]      price_q;
  logic [QUANTITY_WIDTH-1:0]   qty_q;
  logic                        hit, full, hit_q, full_q;
  logic [IDX_WIDTH-1:0]        hit_idx, free_idx, hit_idx_q, free_idx_q;
  logic [SUM_WIDTH-1:0]        vol_sum;
  logic [VOLUME_WIDTH-1:0]     vol_next;
  logic [PRICE_WIDTH:0]        delta;
  logic                        clear_req;
  logic                        is_trade;

`ifdef SYMBOL_STATS_CLEAR_EN
  assign clear_req = clear;
`else
  assign clear_req = 1'b0;
`endif

  assign in_ready  = (state_q == ST_IDLE) && !clear_req;
  assign out_valid = (state_q == ST_EMIT);
  assign is_trade  = (msg_type_t'(in_msg_type) == MSG_TRADE);

  always_comb begin
    for (int i = 0; i < NUM_SYMBOLS; i++) begin
      entry_valid[i]  = table_q[i].valid;
      entry_symbol[i] = table_q[i].symbol;
    end
  end

  symbol_cam_lookup #(
    .NUM_SYMBOLS (NUM_SYMBOLS),
    .SYMBOL_WIDTH(SYMBOL_WIDTH),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_cam (
    .entry_valid (entry_valid),
    .entry_symbol(entry_symbol),
    .key         (sym_q),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .free_idx    (free_idx),
    .full        (full)
  );

  // One extra bit catches the carry so the volume pins at all-ones instead of wrapping.
  always_comb begin
    vol_sum  = {1'b0, table_q[hit_idx_q].volume} + SUM_WIDTH'(qty_q);
    vol_next = vol_sum[VOLUME_WIDTH] ? '1 : vol_sum[VOLUME_WIDTH-1:0];
    delta    = {1'b0, price_q} - {1'b0, table_q[hit_idx_q].last_price};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid && in_ready && is_trade) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_UPDATE;
      ST_UPDATE: state_d = (hit_q || !full_q) ? ST_EMIT : ST_IDLE;
      ST_EMIT:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < NUM_SYMBOLS; i++) table_q[i] <= '0;
      sym_q        <= '0;
      price_q      <= '0;
      qty_q        <= '0;
      hit_q        <= 1'b0;
      full_q       <= 1'b0;
      hit_idx_q    <= '0;
      free_idx_q   <= '0;
      out_symbol   <= '0;
      out_price    <= '0;
      out_delta    <= '0;
      out_volume   <= '0;
      out_index    <= '0;
      out_first    <= 1'b0;
      drop_count   <= '0;
      ignore_count <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            for (int i = 0; i < NUM_SYMBOLS; i++) table_q[i].valid <= 1'b0;
          end else if (in_valid) begin
            if (is_trade) begin
              sym_q   <= in_symbol;
              price_q <= in_price;
              qty_q   <= in_quantity;
            end else if (~&ignore_count) begin
              ignore_count <= ignore_count + CNT_WIDTH'(1);
            end
          end
        end
        ST_LOOKUP: begin
          hit_q      <= hit;
          hit_idx_q  <= hit_idx;
          free_idx_q <= free_idx;
          full_q     <= full;
        end
        ST_UPDATE: begin
          if (hit_q) begin
            table_q[hit_idx_q].last_price <= price_q;
            table_q[hit_idx_q].volume     <= vol_next;
            out_symbol <= sym_q;
            out_price  <= price_q;
            out_delta  <= delta;
            out_volume <= vol_next;
            out_index  <= hit_idx_q;
            out_first  <= 1'b0;
          end else if (!full_q) begin
            table_q[free_idx_q] <= '{valid: 1'b1, symbol: sym_q, last_price: price_q,
                                     volume: VOLUME_WIDTH'(qty_q)};
            out_symbol <= sym_q;
            out_price  <= price_q;
            out_delta  <= '0;
            out_volume <= VOLUME_WIDTH'(qty_q);
            out_index  <= free_idx_q;
            out_first  <= 1'b1;
          end else if (~&drop_count) begin
            drop_count <= drop_count + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_symbol_trade_stats.sv
// tb/tb_symbol_trade_stats.sv - directed self-checking bench for symbol_trade_stats
module tb_symbol_trade_stats;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_symbol = '0;
  logic [31:0] in_price = '0;
  logic [31:0] in_quantity = '0;
  logic [1:0]  in_msg_type = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_first;
  logic [31:0] out_symbol, out_price;
  logic [32:0] out_delta;
  logic [47:0] out_volume;
  logic [2:0]  out_index;
  logic [15:0] drop_count, ignore_count;

  logic        s_in_ready, s_out_valid, s_out_first;
  logic [31:0] s_out_symbol, s_out_price;
  logic [32:0] s_out_delta;
  logic [32:0] s_out_volume;
  logic [2:0]  s_out_index;
  logic [15:0] s_drop_count, s_ignore_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  symbol_trade_stats dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_symbol(in_symbol), .in_price(in_price),
    .in_quantity(in_quantity), .in_msg_type(in_msg_type),
    .out_valid(out_valid), .out_ready(out_ready), .out_symbol(out_symbol), .out_price(out_price),
    .out_delta(out_delta), .out_volume(out_volume), .out_index(out_index), .out_first(out_first),
    .drop_count(drop_count), .ignore_count(ignore_count)
  );

  // Narrow-volume instance sharing the same stimulus, used to reach saturation quickly.
  symbol_trade_stats #(.VOLUME_WIDTH(33)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_symbol(in_symbol), .in_price(in_price),
    .in_quantity(in_quantity), .in_msg_type(in_msg_type),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_symbol(s_out_symbol), .out_price(s_out_price),
    .out_delta(s_out_delta), .out_volume(s_out_volume), .out_index(s_out_index), .out_first(s_out_first),
    .drop_count(s_drop_count), .ignore_count(s_ignore_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one message at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [31:0] sym, input logic [31:0] price, input logic [31:0] qty,
                      input logic [1:0] mtype);
    check("in_ready_before_send", in_ready, 1'b1);
    in_valid    = 1'b1;
    in_symbol   = sym;
    in_price    = price;
    in_quantity = qty;
    in_msg_type = mtype;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic trade(input logic [31:0] sym, input logic [31:0] price, input logic [31:0] qty,
                       input logic [32:0] exp_delta, input logic [47:0] exp_vol,
                       input logic [2:0] exp_idx, input logic exp_first);
    send(sym, price, qty, 2'b01);
    check("lat_n1_valid", out_valid, 1'b0);
    check("lat_n1_ready", in_ready, 1'b0);
    @(negedge clk);
    check("lat_n2_valid", out_valid, 1'b0);
    @(negedge clk);
    check("ev_valid", out_valid, 1'b1);
    check("ev_symbol", out_symbol, sym);
    check("ev_price", out_price, price);
    check("ev_delta", out_delta, exp_delta);
    check("ev_volume", out_volume, exp_vol);
    check("ev_index", out_index, exp_idx);
    check("ev_first", out_first, exp_first);
    @(negedge clk);
    check("ev_done_valid", out_valid, 1'b0);
    check("ev_done_ready", in_ready, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_volume", out_volume, 48'd0);
    check("rst_drop", drop_count, 16'd0);
    check("rst_ignore", ignore_count, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    trade(32'h41414141, 32'd1000, 32'd10, 33'd0, 48'd10, 3'd0, 1'b1);
    trade(32'h41414141, 32'd990, 32'd5, 33'h1_FFFF_FFF6, 48'd15, 3'd0, 1'b0);

    send(32'h41414141, 32'd1, 32'd1, 2'b10);
    check("quote_no_event", out_valid, 1'b0);
    send(32'h41414141, 32'd1, 32'd1, 2'b11);
    check("order_no_event", out_valid, 1'b0);
    send(32'h41414141, 32'd1, 32'd1, 2'b00);
    check("undef_no_event", out_valid, 1'b0);
    check("ignore_count", ignore_count, 16'd3);
    check("ignore_in_ready", in_ready, 1'b1);

    for (int i = 1; i < 8; i++)
      trade(32'h100 + i, 32'(100 * i), 32'(i), 33'd0, 48'(i), 3'(i), 1'b1);
    send(32'h999, 32'd5, 32'd5, 2'b01);
    check("drop_n1_valid", out_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("drop_no_event", out_valid, 1'b0);
    check("drop_count", drop_count, 16'd1);
    check("drop_in_ready", in_ready, 1'b1);
    trade(32'h103, 32'd250, 32'd4, 33'h1_FFFF_FFCE, 48'd7, 3'd3, 1'b0);

    out_ready = 1'b0;
    send(32'h41414141, 32'd1005, 32'd4, 2'b01);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_delta", out_delta, 33'd15);
      check("bp_volume", out_volume, 48'd19);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("bp_release_valid", out_valid, 1'b1);
    @(negedge clk);
    check("bp_single_event", out_valid, 1'b0);

    send(32'h777, 32'd3, 32'd3, 2'b01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_volume", out_volume, 48'd0);
    check("midrst_index", out_index, 3'd0);
    check("midrst_drop", drop_count, 16'd0);
    check("midrst_ignore", ignore_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    trade(32'h5A5A, 32'd7, 32'hFFFF_FFFF, 33'd0, 48'h0_FFFF_FFFF, 3'd0, 1'b1);
    check("sat_s1", s_out_volume, 33'h0_FFFF_FFFF);
    trade(32'h5A5A, 32'd7, 32'hFFFF_FFFF, 33'd0, 48'h1_FFFF_FFFE, 3'd0, 1'b0);
    check("sat_s2", s_out_volume, 33'h1_FFFF_FFFE);
    trade(32'h5A5A, 32'd7, 32'hFFFF_FFFF, 33'd0, 48'h2_FFFF_FFFD, 3'd0, 1'b0);
    check("sat_s3", s_out_volume, 33'h1_FFFF_FFFF);
    trade(32'h5A5A, 32'd9, 32'd1, 33'd2, 48'h2_FFFF_FFFE, 3'd0, 1'b0);
    check("sat_s4_hold", s_out_volume, 33'h1_FFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
